uart_receiver: RTL and testbench

- Serial-to-parallel receiver on FPGA_SERIAL_RX; 8N1 framing; LSB first.
- Sits directly upstream of the Riscv151 memory-mapped UART data/status registers, which consume bytes through a ready/valid handshake.
- Includes an input synchronizer, mid-bit sampling, false-start rejection, framing-error detection and overrun detection.

---
 rtl/uart_receiver_pkg.sv | 34 +++
 rtl/uart_receiver_synchronizer.sv | 37 +++
 rtl/uart_receiver.sv | 181 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART receive-path types, defaults and frame geometry
//
// Contents:
//   UART_FRAME_BITS   : frame length in bits (start + 8 data + stop), also used by the transmitter
//   DEFAULT_CLOCK_FREQ: default clk frequency in Hz
//   DEFAULT_BAUD_RATE : default line rate in bit/s
//   rx_state_e        : 2-bit receiver FSM state encoding
//   symbol_cycles()   : clk cycles per bit for a given clock/baud pair

`ifndef UART_FRAME_BITS
`define UART_FRAME_BITS 10
`endif

package uart_receiver_pkg;

    localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD_RATE  = 115_200;

    localparam int FRAME_BITS = `UART_FRAME_BITS;
    // Start and stop bit are the only framing overhead.
    localparam int DATA_BITS  = FRAME_BITS - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    function automatic int symbol_cycles(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_receiver_synchronizer.sv
// rtl/uart_receiver_synchronizer.sv - two-flop synchronizer for asynchronous inputs
//
// Parameters:
//   WIDTH       : number of independent bits synchronized
//   RESET_VALUE : value both flop stages take while rst_i is high
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : input delayed by two clk_i cycles, safe to use in the clk_i domain

module synchronizer #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 serial receiver with ready/valid byte output
//
// Parameters:
//   CLOCK_FREQ : clk frequency in Hz
//   BAUD_RATE  : line rate in bit/s
// Ports:
//   clk            : single clock, all state changes on posedge
//   rst            : asynchronous active-high reset
//   serial_in      : raw RX line, asynchronous to clk, idles high
//   data_out       : received byte
//   data_out_valid : data_out holds an unconsumed byte
//   data_out_ready : consumer accepts data_out this cycle
//   framing_error  : one-cycle pulse, stop bit sampled low
//   overrun        : one-cycle pulse, a byte was dropped because the holding register was full

module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int SYMBOL_EDGE_TIME    = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME         = SYMBOL_EDGE_TIME / 2;
    localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

    // The counter runs down to zero and the sample is taken on the zero cycle,
    // so reload values are one less than the interval.
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] SAMPLE_RELOAD = CLOCK_COUNTER_WIDTH'(SAMPLE_TIME - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] SYMBOL_RELOAD = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]                     LAST_BIT      = 3'(DATA_BITS - 1);

    logic rx_s;

    synchronizer #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (serial_in),
        .q_o   (rx_s)
    );

    // Edge detector history. Right after reset the synchronizer reports its
    // reset value (idle high) for two cycles whatever the line is doing, so the
    // history is held low until the synchronizer has flushed. Otherwise a line
    // that is low at reset release (mid-frame or break) would look like a
    // fresh start edge.
    logic [1:0] settle_q;
    logic       rx_prev_q;
    logic       settled;

    assign settled = (settle_q == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q  <= 2'd0;
            rx_prev_q <= 1'b0;
        end else begin
            if (!settled) begin
                settle_q <= settle_q + 2'd1;
            end
            rx_prev_q <= settled ? rx_s : 1'b0;
        end
    end

    rx_state_e                      state_q;
    logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt_q;
    logic [2:0]                     bit_idx_q;
    logic [7:0]                     shift_q;
    logic [7:0]                     data_q;
    logic                           valid_q;
    logic                           framing_error_q;
    logic                           overrun_q;

    logic       start_edge;
    logic       sample_now;
    logic       holding_free;
    logic [7:0] shift_d;

    assign start_edge   = !rx_s && rx_prev_q;
    assign sample_now   = (clk_cnt_q == '0);
    // A byte being consumed this cycle frees the register for the new one.
    assign holding_free = !valid_q || data_out_ready;
    // LSB is on the wire first, so each new bit enters at the top.
    assign shift_d      = {rx_s, shift_q[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            clk_cnt_q       <= '0;
            bit_idx_q       <= 3'd0;
            shift_q         <= 8'h00;
            data_q          <= 8'h00;
            valid_q         <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;

            // A load later in this block overrides the clear, so a handshake
            // coinciding with a new byte keeps valid high.
            if (valid_q && data_out_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        clk_cnt_q <= SAMPLE_RELOAD;
                        state_q   <= START;
                    end
                end

                START: begin
                    if (sample_now) begin
                        if (rx_s) begin
                            // Line bounced back high before mid start bit: glitch.
                            state_q <= IDLE;
                        end else begin
                            bit_idx_q <= 3'd0;
                            clk_cnt_q <= SYMBOL_RELOAD;
                            state_q   <= DATA;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - 1'b1;
                    end
                end

                DATA: begin
                    if (sample_now) begin
                        shift_q   <= shift_d;
                        clk_cnt_q <= SYMBOL_RELOAD;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - 1'b1;
                    end
                end

                STOP: begin
                    if (sample_now) begin
                        state_q <= IDLE;
                        if (!rx_s) begin
                            framing_error_q <= 1'b1;
                        end else if (holding_free) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign framing_error  = framing_error_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard testbench for uart_receiver

module tb_uart_receiver;

    localparam int BIT_CYC = 434;
    localparam int LATENCY = 4126;

    logic       clk            = 1'b0;
    logic       rst            = 1'b1;
    logic       serial_in      = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       framing_error;
    logic       overrun;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int edge_cyc = 0;
    int rise_cyc = -1;
    int fe_cyc   = -1;
    int fe_cnt   = 0;
    int ovr_cnt  = 0;
    int fe0, ovr0, rise0;

    logic       prev_valid = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] exp_q[$];

    uart_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid && !prev_valid) rise_cyc = cyc;
            if (framing_error) begin
                fe_cnt = fe_cnt + 1;
                fe_cyc = cyc;
            end
            if (overrun) ovr_cnt = ovr_cnt + 1;
            if (data_out_valid && data_out_ready) begin
                tests = tests + 1;
                if (exp_q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL sb_unexpected_byte: got 0x%02h, expected no byte", data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (data_out !== mon_exp) begin
                        fails = fails + 1;
                        $display("FAIL sb_data: got 0x%02h, expected 0x%02h", data_out, mon_exp);
                    end
                end
            end
        end
        prev_valid = data_out_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Both tasks assume they are entered 1 time unit after a rising clock edge.
    task automatic drive_bit(input logic v);
        serial_in = v;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        edge_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        cycles(30);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_framing_error", int'(framing_error), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        cycles(10);

        // Basic byte with ready low, then handshake
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("a5_latency", rise_cyc - edge_cyc, LATENCY);
        check("a5_valid", int'(data_out_valid), 1);
        check("a5_data", int'(data_out), 'hA5);
        cycles(50);
        check("a5_hold_valid", int'(data_out_valid), 1);
        check("a5_hold_data", int'(data_out), 'hA5);
        data_out_ready = 1'b1;
        cycles(1);
        data_out_ready = 1'b0;
        @(negedge clk);
        check("a5_valid_drop", int'(data_out_valid), 0);
        check("a5_sb_empty", exp_q.size(), 0);
        cycles(1);

        // Back-to-back frames, no idle gap, ready tied high
        data_out_ready = 1'b1;
        fe0 = fe_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        cycles(20);
        check("b2b_sb_empty", exp_q.size(), 0);
        check("b2b_no_framing_error", fe_cnt - fe0, 0);

        // False start: 100-cycle glitch, then a real frame
        fe0 = fe_cnt;
        serial_in = 1'b0;
        cycles(100);
        serial_in = 1'b1;
        cycles(400);
        check("glitch_no_valid", int'(data_out_valid), 0);
        check("glitch_no_framing_error", fe_cnt - fe0, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        cycles(10);
        check("glitch_next_sb_empty", exp_q.size(), 0);

        // Framing error followed by a held-low line
        data_out_ready = 1'b0;
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b0);
        check("fe_pulse_count", fe_cnt - fe0, 1);
        check("fe_pulse_time", fe_cyc - edge_cyc, LATENCY);
        check("fe_no_valid", int'(data_out_valid), 0);
        cycles(5000);
        check("break_no_rearm_fe", fe_cnt - fe0, 1);
        check("break_no_rearm_valid", int'(data_out_valid), 0);
        serial_in = 1'b1;
        cycles(2 * BIT_CYC);
        data_out_ready = 1'b1;
        exp_q.push_back(8'hE7);
        send_frame(8'hE7, 1'b1);
        cycles(10);
        check("break_recover_sb_empty", exp_q.size(), 0);

        // Overrun, then handshake on the exact load cycle
        data_out_ready = 1'b0;
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        check("ovr_first_valid", int'(data_out_valid), 1);
        check("ovr_first_data", int'(data_out), 'h11);
        send_frame(8'h22, 1'b1);
        check("ovr_pulse_count", ovr_cnt - ovr0, 1);
        check("ovr_data_kept", int'(data_out), 'h11);
        check("ovr_valid_kept", int'(data_out_valid), 1);
        exp_q.push_back(8'h33);
        fork
            send_frame(8'h33, 1'b1);
            begin
                cycles(LATENCY - 1);
                data_out_ready = 1'b1;
                cycles(1);
                data_out_ready = 1'b0;
                check("simul_valid_stays", int'(data_out_valid), 1);
                check("simul_new_data", int'(data_out), 'h33);
            end
        join
        check("simul_no_overrun", ovr_cnt - ovr0, 1);
        data_out_ready = 1'b1;
        cycles(1);
        data_out_ready = 1'b0;
        check("simul_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a frame
        fe0   = fe_cnt;
        rise0 = rise_cyc;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                cycles(2000);
                rst = 1'b1;
                #1;
                check("midrst_data_out", int'(data_out), 0);
                check("midrst_valid", int'(data_out_valid), 0);
                cycles(5);
                rst = 1'b0;
            end
        join
        cycles(4400);
        check("midrst_no_valid", rise_cyc, rise0);
        check("midrst_no_framing_error", fe_cnt - fe0, 0);
        data_out_ready = 1'b1;
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        cycles(10);
        check("midrst_next_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
